// File: rtl/prbs_stream_ctrl.sv
// PRBS word sequencer: LFSR state register, bit_masked word expander, valid/ready out.
// Optional PRBS_ERR_INJECT_EN adds err_inject to flip bit 0 of one accepted word.
module bit_masked #(
  parameter int unsigned POL_W = 7,
  parameter logic [POL_W:0] POL_MASK = 8'hC0,
  parameter int unsigned DW = 16
) (
  input  logic [POL_W-1:0] state_i,
  output logic [DW-1:0]    pn_o
);

  logic [POL_W-1:0] s;
  logic             fb;

  // Step the Fibonacci LFSR DW times; first generated bit lands in the MSB.
  always_comb begin
    s    = state_i;
    fb   = 1'b0;
    pn_o = '0;
    for (int i = 0; i < DW; i++) begin
      fb = ^(s & POL_MASK[POL_W:1]);
      s  = {s[POL_W-2:0], fb};
      pn_o[DW-1-i] = fb;
    end
  end

endmodule

module prbs_stream_ctrl #(
  parameter int unsigned POL_W = 7,
  parameter logic [POL_W:0] POL_MASK = 8'hC0,
  parameter int unsigned DW = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [POL_W-1:0] seed,
  input  logic             start,
  input  logic             stop,
`ifdef PRBS_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  input  logic [CNT_W-1:0] burst_len,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [POL_W-1:0] state_q, state_d;
  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    pn;
  logic             accept;
  logic             last_word;

  bit_masked #(
    .POL_W   (POL_W),
    .POL_MASK(POL_MASK),
    .DW      (DW)
  ) u_pn (
    .state_i(state_q),
    .pn_o   (pn)
  );

  assign out_valid = (fsm_q == S_RUN);
  assign busy      = (fsm_q == S_RUN);
  assign done      = (fsm_q == S_DONE);
  assign word_cnt  = cnt_q;
  assign accept    = out_valid & out_ready;
  assign last_word = (len_q != '0) &&
                     (cnt_q == len_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    fsm_d   = fsm_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (fsm_q == S_IDLE): begin
        // Zero seed would lock the LFSR, so it maps to all-ones.
        if (seed_load) begin
          state_d = (seed == '0) ? '1 : seed;
        end
        if (start) begin
          fsm_d = S_RUN;
          len_d = burst_len;
          cnt_d = '0;
        end
      end
      (fsm_q == S_RUN): begin
        if (accept) begin
          state_d = pn[POL_W-1:0];
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if (stop) begin
          fsm_d = S_IDLE;
        end else if (accept && last_word) begin
          fsm_d = S_DONE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '1;
      fsm_q   <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fsm_q   <= fsm_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end
    if (err_inject) begin
      err_d = 1'b1;
    end
    if (stop) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_data = pn ^ {{(DW-1){1'b0}}, err_q & out_valid};
`else
  assign out_data = pn;
`endif

endmodule

// File: tb/tb_prbs_stream_ctrl.sv
// Bench for prbs_stream_ctrl: constant vectors, bit-recurrence PRBS7 model,
// random bursts and hand sequences for stop, reset and ready stalls.
module tb_prbs_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [6:0]  seed;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;
`ifdef PRBS_ERR_INJECT_EN
  logic        err_inject;
`endif

  int checks;
  int errors;

  prbs_stream_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_load(seed_load),
    .seed     (seed),
    .start    (start),
    .stop     (stop),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .burst_len(burst_len),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [6:0]  seed;
    logic [15:0] len;
    logic [15:0] first;
    logic [15:0] after;
  } vec_t;

  vec_t tbl[4];

  // PRBS7 as a bit stream: b[n] = b[n-7] ^ b[n-6], state = last 7 bits
  // oldest-first; a word is the next 16 bits, earliest bit in the MSB.
  function automatic logic [22:0] pn_gen(input logic [6:0] st);
    bit          q[$];
    bit          nb;
    logic [15:0] w;
    logic [6:0]  nx;
    w  = '0;
    nx = '0;
    for (int i = 6; i >= 0; i--) q.push_back(st[i]);
    for (int k = 0; k < 16; k++) begin
      nb = q[q.size()-7] ^ q[q.size()-6];
      q.push_back(nb);
      w = {w[14:0], nb};
    end
    for (int i = 0; i < 7; i++) nx[6-i] = q[q.size()-7+i];
    return {nx, w};
  endfunction

  function automatic logic [15:0] m_word(input logic [6:0] st);
    logic [22:0] r;
    r = pn_gen(st);
    return r[15:0];
  endfunction

  function automatic logic [6:0] m_next(input logic [6:0] st);
    logic [22:0] r;
    r = pn_gen(st);
    return r[22:16];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input logic [6:0] sd, input logic [15:0] len);
    logic [6:0] st;
    int acc;
    int ndone;
    int cyc;
    st = (sd == 7'd0) ? 7'h7F : sd;
    acc = 0;
    ndone = 0;
    cyc = 0;
    seed = sd;
    seed_load = 1'b1;
    start = 1'b1;
    burst_len = len;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    while (cyc < 200) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("rnd_done_cnt", word_cnt, len);
        chk("rnd_done_valid", out_valid, 1'b0);
        tick();
        break;
      end
      chk("rnd_valid", out_valid, 1'b1);
      chk("rnd_data", out_data, m_word(st));
      chk("rnd_cnt", word_cnt, acc);
      if (out_ready) begin
        st = m_next(st);
        acc++;
      end
      tick();
      cyc++;
    end
    chk("rnd_ndone", ndone, 1);
    @(negedge clk);
    chk("rnd_idle_valid", out_valid, 1'b0);
    chk("rnd_idle_data", out_data, m_word(st));
    tick();
  endtask

  initial begin
    logic [6:0]  st;
    logic [15:0] first;
    logic [15:0] held;
    bit          hold;
    int          nval;
    int          ndone;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    start = 1'b0;
    stop = 1'b0;
    burst_len = '0;
    out_ready = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 1'b0;
`endif

    tbl[0] = '{seed: 7'h7F, len: 16'd1, first: 16'h020C, after: 16'h28F2};
    tbl[1] = '{seed: 7'h00, len: 16'd1, first: 16'h020C, after: 16'h28F2};
    tbl[2] = '{seed: 7'h0C, len: 16'd1, first: 16'h28F2, after: 16'h2CEA};
    tbl[3] = '{seed: 7'h7F, len: 16'd2, first: 16'h020C, after: 16'h2CEA};

    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", word_cnt, 16'd0);
    chk("rst_data", out_data, 16'h020C);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b1;
      seed = tbl[v].seed;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      start = 1'b1;
      burst_len = tbl[v].len;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("tbl_first_valid", out_valid, 1'b1);
      chk("tbl_first_data", out_data, tbl[v].first);
      nval = 0;
      ndone = 0;
      for (int c = 0; c < int'(tbl[v].len) + 2; c++) begin
        if (c != 0) @(negedge clk);
        if (out_valid) nval++;
        if (done) begin
          ndone++;
          chk("tbl_done_cnt", word_cnt, tbl[v].len);
        end
        tick();
      end
      @(negedge clk);
      chk("tbl_nvalid", nval, tbl[v].len);
      chk("tbl_ndone", ndone, 1);
      chk("tbl_idle_valid", out_valid, 1'b0);
      chk("tbl_idle_busy", busy, 1'b0);
      chk("tbl_after", out_data, tbl[v].after);
      tick();
    end

    for (int r = 0; r < 30; r++) begin
      run_random(7'($urandom_range(0, 127)), 16'($urandom_range(1, 12)));
    end

    // Continuous run: 127 words bring the state back to the seed.
    st = 7'h7F;
    seed = 7'h7F;
    seed_load = 1'b1;
    start = 1'b1;
    burst_len = 16'd0;
    out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    first = 16'h0;
    for (int i = 0; i < 127; i++) begin
      @(negedge clk);
      if (i == 0) first = out_data;
      chk("cont_data", out_data, m_word(st));
      st = m_next(st);
      tick();
    end
    @(negedge clk);
    chk("cont_wrap_data", out_data, first);
    chk("cont_wrap_cnt", word_cnt, 16'd127);
    chk("cont_busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_valid", out_valid, 1'b0);
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    chk("stop_cnt", word_cnt, 16'd128);
    chk("stop_data", out_data, 16'h28F2);
    tick();
    @(negedge clk);
    chk("stop_done2", done, 1'b0);
    tick();

    // Ready alternating 1,0,1,0: words held while stalled, exactly 4 out.
    st = 7'h7F;
    seed = 7'h7F;
    seed_load = 1'b1;
    start = 1'b1;
    burst_len = 16'd4;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    nval = 0;
    ndone = 0;
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (out_valid) begin
        if (hold) chk("tog_hold", out_data, held);
        chk("tog_data", out_data, m_word(st));
        if (out_ready) begin
          nval++;
          st = m_next(st);
        end
        hold = !out_ready;
        held = out_data;
      end
      if (done) ndone++;
      tick();
    end
    chk("tog_nwords", nval, 4);
    chk("tog_ndone", ndone, 1);
    chk("tog_cnt", word_cnt, 16'd4);
    @(negedge clk);
    chk("tog_after_valid", out_valid, 1'b0);
    tick();

    // Reset in the middle of a burst.
    seed = 7'h35;
    seed_load = 1'b1;
    start = 1'b1;
    burst_len = 16'd10;
    out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_cnt", word_cnt, 16'd0);
    chk("mrst_data", out_data, 16'h020C);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_after", out_data, 16'h020C);
    tick();

`ifdef PRBS_ERR_INJECT_EN
    seed = 7'h7F;
    seed_load = 1'b1;
    start = 1'b1;
    burst_len = 16'd3;
    out_ready = 1'b0;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    err_inject = 1'b1;
    @(negedge clk);
    chk("err_pre", out_data, 16'h020C);
    tick();
    err_inject = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("err_flip", out_data, 16'h020D);
    tick();
    @(negedge clk);
    chk("err_next", out_data, 16'h28F2);
    tick();
    @(negedge clk);
    chk("err_third", out_data, 16'h2CEA);
    tick();
    @(negedge clk);
    chk("err_done", done, 1'b1);
    tick();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
